alu_handshake_unit: RTL and testbench
=====================================

Name: alu_handshake_unit

Overview:
- Next-generation ALU for the datapath: WIDTH-parametrised, registered result, valid/ready handshake on input and output.
- Executes the existing 32-entry FunSel operation set in half-width (WIDTH/2) or full-width mode.
- Adds an iterative shift-add unsigned multiplier.
- Sits between the register-file read ports and the writeback mux.

Parameters:
- WIDTH, 16, full operand/result width; even, >= 4; H = WIDTH/2 is half width.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- InValid  input  1  operation request
- InReady  output  1  unit can accept a request this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- FunSel  input  5  bit4: 0=half, 1=full; bits3:0 = operation (same encoding as the existing ALU)
- MulOp  input  1  1: multiply, FunSel[3:0] ignored
- WF  input  1  write flags for this operation; sampled at accept
- OutValid  output  1  ALUOut holds a completed result
- OutReady  input  1  consumer takes the result
- ALUOut  output  WIDTH  registered result; half-mode results zero-extended
- FlagsOut  output  4  registered {Z,C,N,O}, bits 3..0

Behaviour:
- Accept = InValid && InReady. A, B, FunSel, MulOp, WF and current C are captured at accept.
- States are IDLE, MUL, DONE.
  - IDLE: on accept with MulOp=0 -> DONE next edge, result and flags registered. On accept with MulOp=1 -> MUL.
  - MUL: one shift-add step per cycle. Step count m = H (half) or WIDTH (full), then -> DONE.
  - DONE: OutValid=1. ALUOut and FlagsOut are stable until OutReady.
    - OutReady && accept: start the next operation; no bubble for single-cycle ops.
    - OutReady with no accept -> IDLE.
- InReady = (state==IDLE) || (state==DONE && OutReady). InReady=0 in MUL.
- Latency: single-cycle ops 1 cycle (OutValid at the edge after accept). Multiply m+1 cycles.
- Width rules: half mode operates on bits H-1:0 only, with msb = bit H-1 and carry out of bit H-1. Full mode msb = bit WIDTH-1.
- Operations:
  - ADD: C = carry out.
  - ADC: adds captured C.
  - SUB: A + ~B + 1, C = borrow (1 when A < B unsigned), O = signed overflow.
  - LSL: C = msb of A.
  - LSR: C = A[0], N = 0.
  - ASR: sign preserved, C = A[0].
  - CSL/CSR: rotate through carry in both modes.
    - CSL result = {A[m-2:0],C}, new C = A msb.
    - CSR result = {C,A[m-1:1]}, new C = A[0].
- Flags update (only if captured WF=1, written on entry to DONE):
  - Z = result (mode width) == 0, always.
  - N = result msb, always (except LSR: N=0).
  - C updated by add/sub/shift/rotate/multiply only.
  - O updated by ADD/ADC/SUB only.
  - Pass/NOT/logic ops leave C and O unchanged.
- Multiply:
  - Half mode: H x H -> WIDTH product, C = 0.
  - Full mode: low WIDTH bits to ALUOut, C = |high half (unsigned overflow).
  - O unchanged.
- WF=0: FlagsOut holds. ADC still uses the current C.
- Reset (any time, including mid-multiply): state=IDLE, ALUOut=0, FlagsOut=0, OutValid=0, InReady=1 after release. The in-flight operation is discarded.
- InValid while InReady=0 is ignored; inputs need not be held.

Decomposition:
- Shared package holds:
  - FunSel operation localparams
  - flag bit indices (Z=3, C=2, N=1, O=0)
  - state encoding
  - mode-bit constant
- One sub-module, alu_mul_iter: start/done shift-add multiplier, parametrised by WIDTH, with a half/full mode input.

Test Plan:
- WIDTH=16, half ADD, A=0x00F0, B=0x0020, WF=1 -> ALUOut=0x0010, FlagsOut=0100 (C=1), OutValid one cycle after accept.
- Full SUB, A=0x0005, B=0x0007, WF=1 -> ALUOut=0xFFFE, FlagsOut=0110 (C=borrow, N=1).
- Full ADD 0xFFFF+0x0001 (WF=1) -> 0x0000, Z=1, C=1. Then back-to-back ADC 0x0001+0x0001 with OutReady=1 -> 0x0003, no bubble cycle.
- Full multiply, 0x0100 x 0x0100, WF=1 -> ALUOut=0x0000, Z=1, C=1, N=0. OutValid exactly 17 cycles after accept; InReady=0 throughout MUL.
- In DONE with OutReady=0 for 3 cycles plus InValid pulses -> ALUOut and FlagsOut stable, InReady=0, no request accepted. Any op with WF=0 -> FlagsOut unchanged.
- Reset asserted on cycle 5 of a full multiply -> OutValid=0, ALUOut=0, FlagsOut=0 immediately. InReady=1 on the first edge after release.

Source files
------------

// File: rtl/alu_handshake_unit_pkg.sv
// alu_handshake_unit_pkg: shared opcodes, flag indices, FSM encoding and mode bit
package alu_handshake_unit_pkg;
    localparam logic [3:0] OP_PASSA = 4'h0;
    localparam logic [3:0] OP_PASSB = 4'h1;
    localparam logic [3:0] OP_NOTA  = 4'h2;
    localparam logic [3:0] OP_NOTB  = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_ADC   = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_AND   = 4'h7;
    localparam logic [3:0] OP_OR    = 4'h8;
    localparam logic [3:0] OP_XOR   = 4'h9;
    localparam logic [3:0] OP_NAND  = 4'hA;
    localparam logic [3:0] OP_LSL   = 4'hB;
    localparam logic [3:0] OP_LSR   = 4'hC;
    localparam logic [3:0] OP_ASR   = 4'hD;
    localparam logic [3:0] OP_CSL   = 4'hE;
    localparam logic [3:0] OP_CSR   = 4'hF;
    localparam int FL_Z = 3;
    localparam int FL_C = 2;
    localparam int FL_N = 1;
    localparam int FL_O = 0;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int MODE_BIT = 4;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add unsigned multiplier, one step per cycle, H or WIDTH steps
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_full,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);
    localparam int H = WIDTH / 2;
    localparam int CW = $clog2(WIDTH + 1);
    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   w_mask;
    assign w_mask = i_full ? '1 : {{(WIDTH-H){1'b0}}, {H{1'b1}}};
    // The product includes the step in flight, so the final step is visible as o_done rises
    assign o_prod = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done = r_busy && (r_cnt == CW'(1));
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= i_full ? CW'(WIDTH) : CW'(H);
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a & w_mask};
            r_mplier <= i_b & w_mask;
        end else if (r_busy) begin
            r_acc    <= o_prod;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1))
                r_busy <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_handshake_unit.sv
// alu_handshake_unit: half/full-width ALU with registered result, valid/ready handshake
// and an iterative multiplier
module alu_handshake_unit #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [4:0]       i_fun_sel,
    input  logic             i_mul_op,
    input  logic             i_wf,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_alu_out,
    output logic [3:0]       o_flags_out
);
    import alu_handshake_unit_pkg::*;
    localparam int H = WIDTH / 2;
    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_alu_out;
    logic [3:0]         r_flags;
    logic               r_wf;
    logic               r_full;
    logic               w_accept, w_full, w_arith, w_cin, w_cout, w_new_c;
    logic               w_am_msb, w_bx_msb, w_res_msb, w_ov, w_mul_done;
    logic [3:0]         w_op, w_flags, w_mflags;
    logic [WIDTH-1:0]   w_mask, w_top, w_am, w_bm, w_bx, w_res, w_mres;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    assign w_op        = i_fun_sel[3:0];
    assign w_full      = i_fun_sel[MODE_BIT];
    assign o_in_ready  = (r_state != ST_MUL) && (r_state != ST_DONE || i_out_ready);
    assign o_out_valid = r_state == ST_DONE;
    assign o_alu_out   = r_alu_out;
    assign o_flags_out = r_flags;
    assign w_accept    = i_in_valid && o_in_ready;
    // w_top marks the msb of the active mode; half-mode operands are masked to H bits
    assign w_mask   = w_full ? '1 : {{(WIDTH-H){1'b0}}, {H{1'b1}}};
    assign w_top    = w_full ? {1'b1, {(WIDTH-1){1'b0}}} : {{(WIDTH-H){1'b0}}, 1'b1, {(H-1){1'b0}}};
    assign w_am     = i_a & w_mask;
    assign w_bm     = i_b & w_mask;
    assign w_bx     = (w_op == OP_SUB) ? (~i_b & w_mask) : w_bm;
    assign w_cin    = (w_op == OP_SUB) || (w_op == OP_ADC && r_flags[FL_C]);
    assign w_sum    = {1'b0, w_am} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_cin};
    assign w_cout   = w_full ? w_sum[WIDTH] : w_sum[H];
    assign w_am_msb  = |(w_am & w_top);
    assign w_bx_msb  = |(w_bx & w_top);
    assign w_res_msb = |(w_res & w_top);
    assign w_arith  = (w_op == OP_ADD) || (w_op == OP_ADC) || (w_op == OP_SUB);
    assign w_ov     = w_arith ? (w_am_msb == w_bx_msb) && (w_res_msb != w_am_msb) : r_flags[FL_O];
    always_comb begin
        w_res   = '0;
        w_new_c = r_flags[FL_C];
        case (w_op)
            OP_PASSA: w_res = w_am;
            OP_PASSB: w_res = w_bm;
            OP_NOTA:  w_res = ~i_a & w_mask;
            OP_NOTB:  w_res = ~i_b & w_mask;
            OP_ADD, OP_ADC: begin
                w_res   = w_sum[WIDTH-1:0] & w_mask;
                w_new_c = w_cout;
            end
            OP_SUB: begin
                w_res   = w_sum[WIDTH-1:0] & w_mask;
                w_new_c = !w_cout;
            end
            OP_AND:   w_res = w_am & w_bm;
            OP_OR:    w_res = w_am | w_bm;
            OP_XOR:   w_res = w_am ^ w_bm;
            OP_NAND:  w_res = ~(w_am & w_bm) & w_mask;
            OP_LSL: begin
                w_res   = (w_am << 1) & w_mask;
                w_new_c = w_am_msb;
            end
            OP_LSR: begin
                w_res   = w_am >> 1;
                w_new_c = w_am[0];
            end
            OP_ASR: begin
                w_res   = (w_am >> 1) | (w_am_msb ? w_top : '0);
                w_new_c = w_am[0];
            end
            OP_CSL: begin
                w_res   = ((w_am << 1) | {{(WIDTH-1){1'b0}}, r_flags[FL_C]}) & w_mask;
                w_new_c = w_am_msb;
            end
            OP_CSR: begin
                w_res   = (w_am >> 1) | (r_flags[FL_C] ? w_top : '0);
                w_new_c = w_am[0];
            end
            default: w_res = '0;
        endcase
    end
    assign w_flags  = {w_res == '0, w_new_c, (w_op != OP_LSR) && w_res_msb, w_ov};
    assign w_mres   = w_prod[WIDTH-1:0];
    assign w_mflags = {w_mres == '0, r_full && |w_prod[2*WIDTH-1:WIDTH], w_mres[WIDTH-1], r_flags[FL_O]};
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_accept && i_mul_op),
        .i_full  (w_full),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_alu_out <= '0;
            r_flags   <= '0;
            r_wf      <= 1'b0;
            r_full    <= 1'b0;
        end else if (r_state == ST_MUL) begin
            if (w_mul_done) begin
                r_state   <= ST_DONE;
                r_alu_out <= w_mres;
                if (r_wf)
                    r_flags <= w_mflags;
            end
        end else if (w_accept) begin
            if (i_mul_op) begin
                r_state <= ST_MUL;
                r_wf    <= i_wf;
                r_full  <= w_full;
            end else begin
                r_state   <= ST_DONE;
                r_alu_out <= w_res;
                if (i_wf)
                    r_flags <= w_flags;
            end
        end else if (r_state == ST_DONE && i_out_ready) begin
            r_state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_alu_handshake_unit.sv
// tb_alu_handshake_unit: directed vectors with a queue scoreboard and an independent output monitor
module tb_alu_handshake_unit;
    typedef struct packed {
        logic [15:0] alu;
        logic [3:0]  flags;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [4:0]  fs = '0;
    logic        mul_op = 1'b0;
    logic        wf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] alu;
    logic [3:0]  flags;
    int          errors = 0;
    int          checks = 0;
    string       tname = "reset";
    exp_t        sb[$];
    exp_t        e_mon;

    always #5 clk = ~clk;

    alu_handshake_unit #(.WIDTH(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_fun_sel   (fs),
        .i_mul_op    (mul_op),
        .i_wf        (wf),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_alu_out   (alu),
        .o_flags_out (flags)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every completed output handshake is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_unexpected_output: got alu=%0h flags=%b expected none", tname, alu, flags);
            end else begin
                e_mon = sb.pop_front();
                check({tname, "_alu"}, 32'(alu), 32'(e_mon.alu));
                check({tname, "_flags"}, 32'(flags), 32'(e_mon.flags));
            end
        end
    end

    task automatic issue(input string nm, input logic [4:0] f, input logic m, input logic [15:0] xa,
                         input logic [15:0] xb, input logic w, input logic [15:0] ea,
                         input logic [3:0] ef, input bit push);
        int n = 0;
        tname = nm;
        fs = f; mul_op = m; a = xa; b = xb; wf = w; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_accept_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push)
            sb.push_back('{alu: ea, flags: ef});
    endtask

    task automatic wait_valid(input int lat, input bit chk_busy);
        int n = 1;
        int busy = 0;
        while (!out_valid && n < 60) begin
            if (in_ready)
                busy++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tname, "_latency"}, 32'(n), 32'(lat));
        if (chk_busy)
            check({tname, "_in_ready_in_mul"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu", 32'(alu), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        issue("half_add", 5'h04, 0, 16'h00F0, 16'h0020, 1, 16'h0010, 4'b0100, 1);
        wait_valid(1, 0);
        issue("full_sub", 5'h16, 0, 16'h0005, 16'h0007, 1, 16'hFFFE, 4'b0110, 1);
        wait_valid(1, 0);
        issue("full_add", 5'h14, 0, 16'hFFFF, 16'h0001, 1, 16'h0000, 4'b1100, 1);
        check("full_add_valid", 32'(out_valid), 32'd1);
        issue("b2b_adc", 5'h15, 0, 16'h0001, 16'h0001, 1, 16'h0003, 4'b0000, 1);
        check("b2b_no_bubble", 32'(out_valid), 32'd1);
        issue("full_mul", 5'h10, 1, 16'h0100, 16'h0100, 1, 16'h0000, 4'b1100, 1);
        wait_valid(17, 1);

        issue("stall_xor", 5'h19, 0, 16'h00FF, 16'h0F0F, 1, 16'h0FF0, 4'b0100, 1);
        out_ready = 1'b0;
        tname = "stall";
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; fs = 5'h14; mul_op = 1'b0; wf = 1'b1;
            a = 16'(i * 3 + 1); b = 16'h0101;
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            check("stall_alu", 32'(alu), 32'h0FF0);
            check("stall_flags", 32'(flags), 32'b0100);
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tname = "stall_xor";
        @(posedge clk);
        #1;
        check("stall_release_idle", 32'(out_valid), 32'd0);

        issue("wf0_sub", 5'h16, 0, 16'h0003, 16'h0001, 0, 16'h0002, 4'b0100, 1);
        wait_valid(1, 0);
        issue("wf0_adc", 5'h15, 0, 16'h0010, 16'h0001, 0, 16'h0012, 4'b0100, 1);
        wait_valid(1, 0);
        issue("half_csl", 5'h0E, 0, 16'h1281, 16'h0000, 1, 16'h0003, 4'b0100, 1);
        wait_valid(1, 0);
        issue("half_csr", 5'h0F, 0, 16'h0002, 16'h0000, 1, 16'h0081, 4'b0010, 1);
        wait_valid(1, 0);
        issue("full_asr", 5'h1D, 0, 16'h8004, 16'h0000, 1, 16'hC002, 4'b0010, 1);
        wait_valid(1, 0);
        issue("full_lsr", 5'h1C, 0, 16'h8001, 16'h0000, 1, 16'h4000, 4'b0100, 1);
        wait_valid(1, 0);
        issue("half_sub_ov", 5'h06, 0, 16'h0080, 16'h0001, 1, 16'h007F, 4'b0001, 1);
        wait_valid(1, 0);
        issue("full_nand", 5'h1A, 0, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 4'b1001, 1);
        wait_valid(1, 0);
        issue("half_mul", 5'h00, 1, 16'hAAFF, 16'h55FF, 1, 16'hFE01, 4'b0011, 1);
        wait_valid(9, 1);
        issue("full_lsl", 5'h1B, 0, 16'h8001, 16'h0000, 1, 16'h0002, 4'b0101, 1);
        wait_valid(1, 0);
        issue("half_nota", 5'h02, 0, 16'h1234, 16'h0000, 1, 16'h00CB, 4'b0111, 1);
        wait_valid(1, 0);
        issue("half_add_mask", 5'h04, 0, 16'hFF10, 16'hAAF1, 1, 16'h0001, 4'b0100, 1);
        wait_valid(1, 0);

        issue("mul_rst", 5'h10, 1, 16'h0003, 16'h0005, 1, 16'h000F, 4'b0000, 0);
        repeat (4) @(posedge clk);
        #2;
        check("mul_rst_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mul_rst_valid", 32'(out_valid), 32'd0);
        check("mul_rst_alu", 32'(alu), 32'd0);
        check("mul_rst_flags", 32'(flags), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mul_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("mul_rst_discarded", 32'(out_valid), 32'd0);

        issue("post_rst_adc", 5'h15, 0, 16'h1234, 16'h0001, 1, 16'h1235, 4'b0000, 1);
        wait_valid(1, 0);
        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
